serial_adder: RTL
=================

// Module: serial_adder
//
// PURPOSE
//   Bit-serial adder/subtractor: accepts two BITS-wide operands over a valid/ready handshake.
//   Computes LSB-first, one bit per clock, through an xor3 sum cell and a carry flip-flop.
//   Returns sum, carry-out and signed overflow over a second valid/ready handshake.
//   Sits between operand fetch and writeback in the area-reduced ALU path.
//
// PARAMETERS
//   BITS   8   operand/result width; legal range 1..64
//
// PORTS
//   clk        in   1      single clock, rising edge
//   reset_n    in   1      asynchronous, active-low reset
//   in_valid   in   1      operands a/b/sub valid
//   in_ready   out  1      block can accept operands this cycle
//   a          in   BITS   operand A
//   b          in   BITS   operand B
//   sub        in   1      1 = A - B (B inverted, carry-in 1); 0 = A + B
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result this cycle
//   sum        out  BITS   result bits
//   carry      out  1      carry-out of MSB (for sub: 1 = no borrow)
//   overflow   out  1      signed overflow: carry into MSB XOR carry out of MSB
//
// BEHAVIOUR
//   - Reset (reset_n low, async): state=IDLE, counter=0, carry FF=0, sum/a/b shift regs=0.
//     in_ready=0 while in reset, 1 in IDLE after reset; out_valid=0, sum=0, carry=0, overflow=0.
//   - States: IDLE -> SHIFT on in_valid&in_ready; SHIFT -> DONE when counter==BITS-1;
//     DONE -> IDLE on out_ready; DONE -> SHIFT on out_ready&in_valid (back-to-back).
//   - in_ready = (state==IDLE) | (state==DONE & out_ready). Never high in SHIFT.
//   - Accept: load a into A shift reg; load b (or ~b if sub) into B shift reg;
//     carry FF = sub; counter=0; latch sub for the operation.
//   - SHIFT, each cycle: bit = xor3(A[0], B[0], carry); carry = maj(A[0], B[0], carry);
//     A,B shift right; bit enters sum reg at MSB, shifting right; counter++.
//     The carry-in to the MSB is captured in the cycle counter==BITS-1 for overflow.
//   - Latency: operands accepted at edge N -> out_valid high after edge N+BITS.
//     BITS=1: one SHIFT cycle.
//   - DONE: out_valid=1; sum/carry/overflow held stable until out_ready; no
//     output changes while out_valid & !out_ready (consumer back-pressure indefinitely).
//   - out_valid deasserts the cycle after out_ready unless back-to-back accept occurs
//     (then out_valid=0 during new SHIFT, new result appears BITS cycles later).
//   - Operand changes on a/b/sub while not accepted have no effect.
//   - Reset mid-SHIFT or mid-DONE aborts immediately; partial result discarded, no out_valid.
//   - Arithmetic: all results modulo 2^BITS; counter width $clog2(BITS) (min 1 bit).
//
// STRUCTURE
//   - serial_adder_pkg: state_t enum {IDLE, SHIFT, DONE} (2-bit), no other shared types.
//   - Sub-module: one xor3 (BITS=1) instance for the sum bit; carry majority is inline
//     logic (maj3 not split out). Control FSM, counter, shift regs live in this file.
//   - FORMAL block: assert in_ready never high in SHIFT; outputs stable while
//     out_valid&!out_ready; out_valid only in DONE; result == a+b / a-b mod 2^BITS
//     against operands captured at accept.
//
// TESTING (BITS=8 unless noted)
//   - Reset: hold reset_n low mid-SHIFT -> out_valid=0, in_ready=0 during reset, in_ready=1 after release.
//   - Add: a=0x3C, b=0x05, sub=0 -> after 8 cycles sum=0x41, carry=0, overflow=0.
//   - Wrap/overflow: a=0x7F,b=0x01 add -> sum=0x80,carry=0,overflow=1; a=0xFF,b=0x01 -> sum=0x00,carry=1,overflow=0.
//   - Subtract: a=0x05,b=0x07,sub=1 -> sum=0xFE,carry=0 (borrow); a=0x80,b=0x01 -> sum=0x7F,overflow=1.
//   - Back-pressure + back-to-back: hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0;
//     then out_ready=1 with in_valid=1 -> new op accepted same cycle, next result 8 cycles later.
//   - BITS=1: a=1,b=1 add -> sum=0,carry=1,overflow=1 after one SHIFT cycle.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding for the bit-serial adder/subtractor
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_xor3.sv
// rtl/serial_adder_xor3.sv - three-input xor sum cell
module serial_adder_xor3 #(
    parameter int BITS = 1
) (
    input  logic [BITS-1:0] x,
    input  logic [BITS-1:0] y,
    input  logic [BITS-1:0] z,
    output logic [BITS-1:0] s
);

    assign s = x ^ y ^ z;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder/subtractor, LSB first, valid/ready on both sides
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] sum,
    output logic            carry,
    output logic            overflow
);

    localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [BITS-1:0] a_sr, b_sr, sum_sr;
    logic            carry_q, ovf_q, rdy_q;
    logic            accept, last, bit_s, carry_d;
    logic [BITS:0]   sum_cat;

    assign last     = (cnt_q == CW'(BITS - 1));
    assign in_ready = rdy_q & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign accept   = in_valid & in_ready;

    serial_adder_xor3 #(.BITS(1)) u_sum_cell (
        .x (a_sr[0]),
        .y (b_sr[0]),
        .z (carry_q),
        .s (bit_s)
    );

    assign carry_d = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry_q) | (b_sr[0] & carry_q);
    // Concatenation keeps the MSB-entry shift legal when BITS == 1.
    assign sum_cat = {bit_s, sum_sr};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (last)   state_d = DONE;
            DONE:    if (out_ready) state_d = accept ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // in_ready stays low until the first clock after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdy_q   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_sr    <= a;
            b_sr    <= sub ? ~b : b;
            carry_q <= sub;
            cnt_q   <= '0;
        end else if (state_q == SHIFT) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            sum_sr  <= sum_cat[BITS:1];
            carry_q <= carry_d;
            cnt_q   <= cnt_q + CW'(1);
            if (last) begin
                ovf_q <= carry_q ^ carry_d;
            end
        end
    end

    assign out_valid = (state_q == DONE);
    assign sum       = sum_sr;
    assign carry     = carry_q;
    assign overflow  = ovf_q;

`ifdef FORMAL
    logic [BITS-1:0] f_a, f_b;
    logic            f_sub;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            f_a   <= '0;
            f_b   <= '0;
            f_sub <= 1'b0;
        end else if (accept) begin
            f_a   <= a;
            f_b   <= b;
            f_sub <= sub;
        end
    end

    a_no_ready_in_shift: assert property (@(posedge clk) disable iff (!reset_n)
        (state_q == SHIFT) |-> !in_ready);
    a_hold_outputs: assert property (@(posedge clk) disable iff (!reset_n)
        (out_valid && !out_ready) |=> (out_valid && $stable(sum) && $stable(carry) && $stable(overflow)));
    a_valid_only_done: assert property (@(posedge clk) disable iff (!reset_n)
        out_valid |-> (state_q == DONE));
    a_result: assert property (@(posedge clk) disable iff (!reset_n)
        out_valid |-> (sum == (f_sub ? (f_a - f_b) : (f_a + f_b))));
`endif

endmodule
